// File: rtl/i2c_eeprom_page_wr_pkg.sv
// Shared definitions for the EEPROM page-write sequencer.
//   - EEPROM geometry (byte depth, default page size)
//   - command code and default device address
//   - sequencer state enum
//   - address arithmetic helper (wraps at the EEPROM depth)
package i2c_eeprom_page_wr_pkg;

  localparam int         EE_DEPTH     = 128;
  localparam int         EE_PAGE_SIZE = 8;
  localparam int         MAX_LEN      = 16;
  localparam logic [3:0] CMD_WR_DEF   = 4'h1;
  localparam logic [6:0] DEV_ADDR_DEF = 7'h50;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    WAIT,
    POLL_REQ,
    POLL_WAIT,
    NEXT,
    DONE,
    FAIL
  } state_e;

  // Byte address plus offset, wrapping at the end of the EEPROM array.
  function automatic logic [6:0] ee_addr_add(input logic [6:0] a, input logic [4:0] n);
    return 7'((int'(a) + int'(n)) % EE_DEPTH);
  endfunction

endpackage

// File: rtl/i2c_chunk_calc.sv
// Chunk size for the next page write: the smaller of the bytes still to be
// written and the bytes left before the next page boundary.
// Ports:
//   addr      - current EEPROM byte address
//   remaining - bytes of the job not yet written
//   chunk     - bytes to write in the next transaction
module i2c_chunk_calc
  import i2c_eeprom_page_wr_pkg::*;
#(
  parameter int PAGE_SIZE = EE_PAGE_SIZE
) (
  input  logic [6:0] addr,
  input  logic [4:0] remaining,
  output logic [4:0] chunk
);

  logic [7:0] room;

  always_comb begin
    room = 8'(PAGE_SIZE) - {1'b0, addr & 7'(PAGE_SIZE - 1)};
    // room may exceed the 5-bit range only when it is larger than any legal
    // remaining count, in which case remaining is selected.
    if ({3'b000, remaining} <= room) begin
      chunk = remaining;
    end else begin
      chunk = room[4:0];
    end
  end

endmodule

// File: rtl/i2c_eeprom_page_wr.sv
// I2C EEPROM page-write sequencer.
// Splits a job of 1..16 bytes into page-aligned write transactions, issues
// each one to an I2C master (address byte followed by data bytes), then
// ACK-polls the EEPROM with address-only writes until its internal write
// cycle completes.
// Ports:
//   clock, rst_n                   - clock, async active-low reset
//   start, mem_addr, length        - job request and its parameters
//   din, din_valid, din_ready      - upstream data bytes
//   m_req, m_ack, m_cmd,
//   m_dev_addr, m_len              - transaction request to the master
//   m_wdata, m_wvalid, m_wready    - write byte stream to the master
//   m_done, m_nack                 - end-of-transaction status
//   busy, finish, error            - job status
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// REQ       | requesting a write transaction of chunk+1 bytes
// ADDR      | sending the EEPROM byte address
// DATA      | passing chunk data bytes from din to the master
// WAIT      | waiting for the write transaction to end
// POLL_REQ  | requesting an address-only write (ACK poll)
// POLL_WAIT | waiting for the poll result
// NEXT      | advancing address / remaining count to the next chunk
// DONE      | job succeeded, finish pulse
// FAIL      | job failed, error pulse
module i2c_eeprom_page_wr
  import i2c_eeprom_page_wr_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         PAGE_SIZE = EE_PAGE_SIZE,
  parameter int         MAX_POLL  = 1023,
  parameter logic [3:0] CMD_WR    = CMD_WR_DEF
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  mem_addr,
  input  logic [4:0]  length,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        m_req,
  input  logic        m_ack,
  output logic [3:0]  m_cmd,
  output logic [6:0]  m_dev_addr,
  output logic [23:0] m_len,
  output logic [7:0]  m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_done,
  input  logic        m_nack,
  output logic        busy,
  output logic        finish,
  output logic        error
);

  localparam int PW = (MAX_POLL < 1) ? 1 : $clog2(MAX_POLL + 1);

  state_e          state_q, state_d;
  logic [6:0]      addr_q, addr_d;
  logic [4:0]      remaining_q, remaining_d;
  logic [4:0]      byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [PW-1:0]   poll_inc;
  logic [4:0]      chunk;
  logic            len_ok;

  // addr_q/remaining_q only move in NEXT, so chunk is stable for the whole
  // transaction that uses it.
  i2c_chunk_calc #(
    .PAGE_SIZE (PAGE_SIZE)
  ) u_chunk (
    .addr      (addr_q),
    .remaining (remaining_q),
    .chunk     (chunk)
  );

  assign len_ok   = (length != 5'd0) && (length <= 5'(MAX_LEN));
  assign poll_inc = poll_cnt_q + 1'b1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      poll_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_cnt_d  = byte_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d     = REQ;
            addr_d      = mem_addr;
            remaining_d = length;
            byte_cnt_d  = '0;
            poll_cnt_d  = '0;
          end else begin
            state_d = FAIL;
          end
        end
      end
      REQ: begin
        if (m_ack) state_d = ADDR;
      end
      ADDR: begin
        if (m_wready) state_d = DATA;
      end
      DATA: begin
        if (din_valid && m_wready) begin
          if (byte_cnt_q == chunk - 5'd1) begin
            state_d    = WAIT;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      WAIT: begin
        if (m_done) state_d = m_nack ? FAIL : POLL_REQ;
      end
      POLL_REQ: begin
        if (m_ack) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (m_done) begin
          if (!m_nack) begin
            state_d = NEXT;
          end else begin
            poll_cnt_d = poll_inc;
            state_d    = (int'(poll_inc) < MAX_POLL) ? POLL_REQ : FAIL;
          end
        end
      end
      NEXT: begin
        addr_d      = ee_addr_add(addr_q, chunk);
        remaining_d = remaining_q - chunk;
        poll_cnt_d  = '0;
        state_d     = (remaining_q == chunk) ? DONE : REQ;
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready  = 1'b0;
    m_req      = 1'b0;
    m_cmd      = '0;
    m_dev_addr = '0;
    m_len      = '0;
    m_wdata    = '0;
    m_wvalid   = 1'b0;
    finish     = 1'b0;
    error      = 1'b0;
    busy       = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
    case (state_q)
      REQ: begin
        m_req      = 1'b1;
        m_cmd      = CMD_WR;
        m_dev_addr = DEV_ADDR;
        m_len      = 24'(chunk) + 24'd1;
      end
      POLL_REQ: begin
        m_req      = 1'b1;
        m_cmd      = CMD_WR;
        m_dev_addr = DEV_ADDR;
      end
      ADDR: begin
        m_wdata  = {1'b0, addr_q};
        m_wvalid = 1'b1;
      end
      DATA: begin
        m_wdata   = din;
        m_wvalid  = din_valid;
        din_ready = m_wready;
      end
      DONE:    finish = 1'b1;
      FAIL:    error  = 1'b1;
      default: ;
    endcase
  end

endmodule
